mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU, with its own HI/LO registers.
- Sits directly downstream of the register file. It consumes the rs/rt read data and holds results for MFHI/MFLO.
- Control drives start/op. Writeback muxes o_hi/o_lo into the register-file write data when MFHI/MFLO executes.
- A busy flag lets control stall the PC while an operation runs.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  request a new operation; sampled only in IDLE.
- i_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_rs_data  input  DATA_W  rs read data: multiplicand or dividend.
- i_rt_data  input  DATA_W  rt read data: multiplier or divisor.
- i_mthi  input  1  write i_rs_data into HI (MTHI).
- i_mtlo  input  1  write i_rs_data into LO (MTLO).
- o_busy  output  1  operation in progress.
- o_done  output  1  one-cycle pulse; HI/LO updated.
- o_hi  output  DATA_W  HI register.
- o_lo  output  DATA_W  LO register.

Behaviour:
- Reset: one clock with i_rst high forces:
  - state IDLE
  - HI = LO = 0
  - o_busy = 0, o_done = 0
  - counter and working registers = 0
- Reset mid-operation aborts the operation, discards partial results and behaves exactly as above.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - When i_start = 1, latch op and operands.
  - Signed ops: latch magnitudes and record the result signs.
  - Clear the counter and go to CALC.
  - Otherwise, if i_mthi or i_mtlo is high, update HI/LO from i_rs_data on that edge. Both may be high together.
  - If start and an mt* signal occur in the same cycle, start wins and mt* is ignored.
- CALC: one iteration per clock, DATA_W iterations.
  - Multiply: radix-2 shift-add into a 2*DATA_W accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Go to FIX when the counter reaches DATA_W-1 and completes.
- FIX: apply signs and write HI/LO, then go to IDLE with o_done = 1 for exactly one cycle.
  - Multiply: two's-complement negate the 64-bit product if the signs differ. {HI,LO} = product.
  - Divide: LO = quotient, negated if the signs differ. HI = remainder, carrying the sign of the dividend.
- Latency: start sampled at edge k; o_busy high from edge k+1 through edge k+34 (34 cycles); o_done and new HI/LO visible after edge k+34.
- o_busy is registered and high in CALC and FIX. In IDLE, start, mthi and mtlo are the only accepted inputs; i_start while busy is ignored with no queuing.
- Divide by zero:
  - Detected at start and keeps the full latency.
  - Result LO = all ones, HI = i_rs_data as latched, for both DIV and DIVU.
  - No trap.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0. This falls out of the magnitude path and must not be special-cased wrongly.
- Operands are latched at start; later changes on i_rs_data/i_rt_data have no effect.
- HI/LO hold their value between operations.

Decomposition:
- Shared include file mdu_defs.vh holds:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU
  - state encodings
  - DATA_W default
- One natural sub-module, mdu_datapath: accumulator/remainder shift registers and the add/subtract per iteration.
- The top level holds the FSM, counter, sign handling and HI/LO registers.

Test Plan:
- Reset, then MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> after 34 cycles HI=0xFFFFFFFE, LO=0x00000001, o_done pulses once, o_busy high exactly 34 cycles.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV rs=-7 (0xFFFFFFF9) rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU rs=100 rt=7 -> LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=0x1234 rt=0 -> LO=0xFFFFFFFF, HI=0x1234 after full latency; same for DIV.
- While busy:
  - Second i_start is ignored.
  - i_mthi with rs=0xAAAA is ignored.
  - Operand inputs toggled each cycle -> result equals the first operation's values.
  - After completion, i_mthi rs=0xAAAA then i_mtlo rs=0x5555 -> HI=0xAAAA, LO=0x5555.
- Assert i_rst at cycle 10 of a DIV -> next cycle o_busy=0, HI=LO=0, no o_done. A subsequent MULTU 3x5 -> LO=15, HI=0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MDU_* : i_op encodings (MULT, MULTU, DIV, DIVU)
//   - state_e : FSM states of the top level
//   - MDU_DATA_W : default operand / HI / LO width
package mult_div_unit_pkg;

  localparam int MDU_DATA_W = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mult_div_unit_datapath.sv
// Iterative datapath shared by multiply and divide.
// Holds a 2*DATA_W working register:
//   multiply : {partial product, multiplier bits not yet consumed}
//   divide   : {partial remainder, dividend bits / quotient bits}
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : load i_a into the low half, clear the high half
//   i_step       : perform one iteration
//   i_is_div     : 1 = restoring divide step, 0 = shift-add multiply step
//   i_a          : multiplier / dividend magnitude
//   i_b          : multiplicand / divisor magnitude
//   o_acc        : working register
module mult_div_unit_datapath #(
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_is_div,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic [2*DATA_W-1:0]   o_acc
);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W:0]     add_sum;
  logic [DATA_W:0]     sub_diff;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set; the carry becomes the new top bit after shifting.
    add_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
             + {1'b0, (acc_q[0] ? i_b : {DATA_W{1'b0}})};
    // Divide: trial subtract from the remainder shifted left by one with the
    // next dividend bit. A set top bit means the trial went negative.
    sub_diff = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, i_b};

    acc_d = acc_q;
    if (i_load) begin
      acc_d = {{DATA_W{1'b0}}, i_a};
    end else if (i_step) begin
      if (i_is_div) begin
        if (sub_diff[DATA_W]) acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
        else                  acc_d = {sub_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_d = {add_sum, acc_q[DATA_W-1:1]};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// Operands come straight from register-file read data; HI/LO feed writeback
// for MFHI/MFLO. Signed ops run on magnitudes and are sign-fixed at the end.
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_start, i_op      : start request (accepted only when idle) and opcode
//   i_rs_data          : multiplicand / dividend, also MTHI/MTLO source
//   i_rt_data          : multiplier / divisor
//   i_mthi, i_mtlo     : write i_rs_data into HI / LO when idle
//   o_busy             : operation in progress (34 cycles)
//   o_done             : one-cycle pulse when HI/LO take a new result
//   o_hi, o_lo         : HI / LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic              i_mthi,
  input  logic              i_mtlo,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ld_q;
  logic                is_div_q, neg_res_q, neg_rem_q, dz_q;
  logic [DATA_W-1:0]   rs_q, a_q, b_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                busy_q, done_q;

  // Decode of the incoming request
  logic                is_div, is_signed, rs_neg, rt_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;

  always_comb begin
    is_div    = (i_op == MDU_DIV) || (i_op == MDU_DIVU);
    is_signed = (i_op == MDU_MULT) || (i_op == MDU_DIV);
    rs_neg    = is_signed & i_rs_data[DATA_W-1];
    rt_neg    = is_signed & i_rt_data[DATA_W-1];
    // The most negative value is its own two's-complement, which is exactly
    // its magnitude when read as unsigned.
    a_mag     = rs_neg ? -i_rs_data : i_rs_data;
    b_mag     = rt_neg ? -i_rt_data : i_rt_data;
  end

  // Datapath: loaded on the first CALC cycle from the latched magnitudes,
  // then DATA_W iterations.
  logic [2*DATA_W-1:0] acc;
  logic                dp_step;

  assign dp_step = (state_q == ST_CALC) && !ld_q;

  mult_div_unit_datapath #(.DATA_W(DATA_W)) u_dp (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (ld_q),
    .i_step   (dp_step),
    .i_is_div (is_div_q),
    .i_a      (a_q),
    .i_b      (b_q),
    .o_acc    (acc)
  );

  // Sign fix-up of the raw magnitude result
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod   = neg_res_q ? -acc : acc;
    fix_hi = prod[2*DATA_W-1:DATA_W];
    fix_lo = prod[DATA_W-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        // Divide by zero: no trap, fixed result pattern
        fix_hi = rs_q;
        fix_lo = '1;
      end else begin
        fix_lo = neg_res_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        fix_hi = neg_rem_q ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ld_q      <= 1'b0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      rs_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ld_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            is_div_q  <= is_div;
            neg_res_q <= rs_neg ^ rt_neg;
            neg_rem_q <= rs_neg;
            dz_q      <= is_div && (i_rt_data == '0);
            rs_q      <= i_rs_data;
            a_q       <= a_mag;
            b_q       <= b_mag;
            cnt_q     <= '0;
            ld_q      <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_CALC;
          end else begin
            if (i_mthi) hi_q <= i_rs_data;
            if (i_mtlo) lo_q <= i_rs_data;
          end
        end
        ST_CALC: begin
          if (!ld_q) begin
            if (cnt_q == CNT_W'(DATA_W-1)) state_q <= ST_FIX;
            else                           cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        ST_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference HI/LO state
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_op      (op),
    .i_rs_data (rs),
    .i_rt_data (rt),
    .i_mthi    (mthi),
    .i_mtlo    (mtlo),
    .o_busy    (busy),
    .o_done    (done),
    .o_hi      (hi),
    .o_lo      (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {HI,LO} from plain integer arithmetic
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return 64'(ua * ub);
      2'b10: if (b == 0) return {a, 32'hFFFF_FFFF};
             else        return {32'(sa % sb), 32'(sa / sb)};
      default: if (b == 0) return {a, 32'hFFFF_FFFF};
               else        return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  task automatic idle_inputs();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
  endtask

  // Issue one op; with noise, junk is driven on every input while busy.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit noise, input bit mt_with_start);
    int busy_n = 0;
    int guard  = 0;
    logic [63:0] exp;
    exp = ref_model(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    mthi = mt_with_start; mtlo = mt_with_start;
    @(negedge clk);
    idle_inputs();
    while (!done && guard < 100) begin
      if (busy) busy_n++;
      if (noise) begin
        start = 1'b1;
        mthi  = 1'b1;
        mtlo  = 1'($urandom);
        op    = 2'($urandom);
        rs    = (guard == 0) ? 32'h0000_AAAA : $urandom;
        rt    = $urandom;
      end
      @(negedge clk);
      guard++;
    end
    idle_inputs();
    chk({tag, "_timeout"}, 64'(guard >= 100), 64'd0);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd34);
    chk({tag, "_done_busy"}, {63'd0, busy}, 64'd0);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  task automatic mt_write(input bit wh, input bit wl, input logic [31:0] v);
    @(negedge clk);
    mthi = wh; mtlo = wl; rs = v;
    @(negedge clk);
    idle_inputs();
    if (wh) m_hi = v;
    if (wl) m_lo = v;
    chk("mt_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("mt_lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; op = 2'b00; rs = '0; rt = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         1'b0, 1'b0);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
    run_op("divu",      2'b11, 32'd100,       32'd7,         1'b0, 1'b0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu_z",    2'b11, 32'h0000_1234, 32'd0,         1'b0, 1'b0);
    run_op("div_z",     2'b10, 32'h0000_1234, 32'd0,         1'b0, 1'b0);
    run_op("div_zneg",  2'b10, 32'hFFFF_0000, 32'd0,         1'b0, 1'b0);
    run_op("start_mt",  2'b00, 32'd12345,     32'hFFFF_FF00, 1'b0, 1'b1);
    run_op("noise",     2'b10, 32'h7654_3210, 32'hFFFF_FFF3, 1'b1, 1'b0);

    mt_write(1'b1, 1'b0, 32'h0000_AAAA);
    mt_write(1'b0, 1'b1, 32'h0000_5555);
    mt_write(1'b1, 1'b1, 32'hDEAD_BEEF);

    // Randomized mix
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = b >> $urandom_range(0, 31);
        2: a = a | 32'h8000_0000;
        default: ;
      endcase
      run_op("rand", 2'($urandom), a, b, 1'($urandom), 1'b0);
    end

    // Reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs = 32'd1000; rt = 32'd3;
    @(negedge clk);
    idle_inputs();
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    chk("abort_nodone", 64'(done_seen), 64'd0);
    run_op("post_rst", 2'b01, 32'd3, 32'd5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
